muldiv_sequencer: RTL

Sequencer between the multicycle CPU control unit and the shared multiply/divide datapath. It accepts one MULT or DIV request at a time and clears the selected unit. It then launches the unit and counts a fixed number of execution cycles, since the units expose no completion flag. Finally it captures the unit's HI/LO into architectural HI/LO registers, or raises a divide-by-zero exception, and holds the CPU via `busy` throughout.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the mult/div sequencer
//
// Purpose: state encoding, operation codes and default execution cycle counts
// used by muldiv_sequencer and anything that drives it.
// Ports: none (package).

package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    WRITE = 3'd4,
    EXC   = 3'd5
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 33;

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - sequences one MULT/DIV through the shared datapath
//
// Purpose: accepts a single MULT or DIV request, clears the selected unit,
// launches it, waits a fixed number of execution cycles (the units have no
// completion flag), then captures the unit's HI/LO into the architectural
// HI/LO registers or raises a divide-by-zero exception. busy stalls the CPU
// for the whole sequence.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, op           request pulse and operation (0 = MULT, 1 = DIV), IDLE only
//   mult_hi, mult_lo    multiplier result
//   div_hi, div_lo      divider result (hi = remainder, lo = quotient)
//   div0                divider divide-by-zero flag
//   unit_clear          reset pulse to the selected unit
//   mult_go, div_go     launch strobes to the multiplier / divider
//   busy                high whenever the sequencer is not idle
//   done                one-cycle completion pulse
//   div0_exc            one-cycle divide-by-zero exception pulse
//   hi, lo              architectural HI/LO registers

import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        div0,
  output logic        unit_clear,
  output logic        mult_go,
  output logic        div_go,
  output logic        busy,
  output logic        done,
  output logic        div0_exc,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t     state;
  logic       op_q;
  logic [5:0] cnt;
  logic [5:0] last_cnt;

  // Final RUN cycle index for the operation in flight.
  assign last_cnt = (op_q == OP_DIV) ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);

  // Outputs are registered alongside the state transition so each one is
  // exactly the decode of the state being entered (Moore behaviour).
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_MULT;
      cnt        <= 6'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      unit_clear <= 1'b0;
      mult_go    <= 1'b0;
      div_go     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
    end else begin
      unit_clear <= 1'b0;
      mult_go    <= 1'b0;
      div_go     <= 1'b0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op;
            state      <= CLEAR;
            busy       <= 1'b1;
            unit_clear <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= LOAD;
          mult_go <= (op_q == OP_MULT);
          div_go  <= (op_q == OP_DIV);
        end
        LOAD: begin
          cnt   <= 6'd0;
          state <= RUN;
        end
        RUN: begin
          // The divider reports div0 in its first execution cycle; that
          // check wins even when the configured run is a single cycle.
          if (op_q == OP_DIV && cnt == 6'd0 && div0) begin
            state    <= EXC;
            done     <= 1'b1;
            div0_exc <= 1'b1;
          end else if (cnt == last_cnt) begin
            state <= WRITE;
            done  <= 1'b1;
            hi    <= (op_q == OP_DIV) ? div_hi : mult_hi;
            lo    <= (op_q == OP_DIV) ? div_lo : mult_lo;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        WRITE, EXC: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
